// File: rtl/iter_mdu.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// with single-cycle shortcuts for divide-by-zero, signed overflow and illegal opcodes.
module iter_mdu #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      mdu_op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int unsigned     PW    = 2 * XLEN;
    localparam logic [XLEN-1:0] WMASK = XLEN'(64'h0000_0000_FFFF_FFFF);
    localparam logic [XLEN-1:0] XMIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [6:0]      NFULL = 7'(XLEN);
    localparam logic [6:0]      NW    = 7'd32;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t r_state, w_state_nx;

    logic [3:0]      r_op;
    logic            r_is_w, r_neg_q, r_neg_r;
    logic [6:0]      r_cnt;
    logic [PW-1:0]   r_acc, r_mcand;
    logic [XLEN-1:0] r_mplier, r_quo, r_rem, r_div, r_result;

    logic            w_is_w, w_is_div, w_is_rem, w_div_s, w_legal;
    logic            w_s1_signed, w_s2_signed, w_neg1, w_neg2;
    logic            w_div0, w_ovf, w_shortcut, w_accept, w_last, w_ge;
    logic [XLEN-1:0] w_op1, w_op2, w_mag1, w_mag2, w_dvd, w_short_res;
    logic [PW-1:0]   w_acc_nx, w_prod;
    logic [XLEN:0]   w_rshift;
    logic [XLEN-1:0] w_rem_nx, w_quo_nx, w_q, w_r, w_sel, w_final;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return v[31] ? (v | ~WMASK) : (v & WMASK);
    endfunction

    // Request decode and shortcut detection, evaluated on the accept cycle.
    always_comb begin
        w_is_w      = mdu_op[3];
        w_is_div    = mdu_op[2];
        w_is_rem    = mdu_op[2] & mdu_op[1];
        w_div_s     = mdu_op[2] & ~mdu_op[0];
        w_legal     = (mdu_op inside {[4'd0:4'd7]}) ||
                      ((XLEN == 64) && (mdu_op inside {4'd8, [4'd12:4'd15]}));
        w_s1_signed = w_div_s | (mdu_op == 4'd1) | (mdu_op == 4'd2);
        w_s2_signed = w_div_s | (mdu_op == 4'd1);
        w_op1       = w_is_w ? (src1 & WMASK) : src1;
        w_op2       = w_is_w ? (src2 & WMASK) : src2;
        w_neg1      = w_s1_signed & (w_is_w ? src1[31] : src1[XLEN-1]);
        w_neg2      = w_s2_signed & (w_is_w ? src2[31] : src2[XLEN-1]);
        w_mag1      = w_neg1 ? (w_is_w ? ((-src1) & WMASK) : -src1) : w_op1;
        w_mag2      = w_neg2 ? (w_is_w ? ((-src2) & WMASK) : -src2) : w_op2;
        w_dvd       = w_is_w ? sext32(src1) : src1;
        w_div0      = (w_op2 == '0);
        w_ovf       = w_div_s & (w_is_w ?
                      ((src1[31:0] == 32'h8000_0000) && (src2[31:0] == 32'hFFFF_FFFF)) :
                      ((src1 == XMIN) && (src2 == '1)));
        w_shortcut  = 1'b1;
        w_short_res = '0;
        if (!w_legal) begin
            w_short_res = '0;
        end else if (w_is_div && w_div0) begin
            w_short_res = w_is_rem ? w_dvd : '1;
        end else if (w_is_div && w_ovf) begin
            w_short_res = w_is_rem ? '0 : w_dvd;
        end else begin
            w_shortcut = 1'b0;
        end
    end

    // One radix-2 step; the final step feeds the sign fix-up directly.
    always_comb begin
        w_acc_nx = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_rshift = {r_rem, r_quo[XLEN-1]};
        w_ge     = (w_rshift >= {1'b0, r_div});
        w_rem_nx = w_ge ? XLEN'(w_rshift - {1'b0, r_div}) : w_rshift[XLEN-1:0];
        w_quo_nx = {r_quo[XLEN-2:0], w_ge};
        w_prod   = r_neg_q ? -w_acc_nx : w_acc_nx;
        w_q      = r_neg_q ? -w_quo_nx : w_quo_nx;
        w_r      = r_neg_r ? -w_rem_nx : w_rem_nx;
        w_sel    = r_op[1] ? w_r : w_q;
        case (r_op)
            4'd0:                w_final = w_prod[XLEN-1:0];
            4'd1, 4'd2, 4'd3:    w_final = w_prod[PW-1:XLEN];
            4'd8:                w_final = sext32(w_prod[XLEN-1:0]);
            default:             w_final = r_is_w ? sext32(w_sel) : w_sel;
        endcase
        w_last = (r_cnt == ((r_is_w ? NW : NFULL) - 7'd1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept   = 1'b1;
                    w_state_nx = w_shortcut ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (w_last) w_state_nx = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nx = StIdle;
            end
            default: w_state_nx = StIdle;
        endcase
        // Abort wins over both a new request and a completing handshake.
        if (flush) begin
            w_state_nx = StIdle;
            w_accept   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_is_w   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op     <= mdu_op;
            r_is_w   <= w_is_w;
            r_neg_q  <= w_neg1 ^ w_neg2;
            r_neg_r  <= w_neg1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= PW'(w_mag1);
            r_mplier <= w_mag2;
            // W divides consume dividend MSB-first from bit 31, so pre-align it to the top.
            r_quo    <= w_is_w ? (w_mag1 << (XLEN - 32)) : w_mag1;
            r_rem    <= '0;
            r_div    <= w_mag2;
            r_result <= w_short_res;
        end else if ((r_state == StCalc) && !flush) begin
            r_acc    <= w_acc_nx;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_quo    <= w_quo_nx;
            r_rem    <= w_rem_nx;
            r_cnt    <= r_cnt + 7'd1;
            if (w_last) r_result <= w_final;
        end
    end

    assign result = out_valid ? r_result : '0;

endmodule

// File: doc/iter_mdu.md
ITER_MDU -- requirements
Module: iter_mdu

Interface
REQ-001 Parameter XLEN, default 64, operand/result width; legal values 32 and 64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 flush  input  1  synchronous abort of any operation in flight.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 mdu_op  input  4  operation code per REQ-012.
REQ-008 src1, src2  input  XLEN each  operands (rs1, rs2).
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  XLEN  operation result.

Function
REQ-012 mdu_op codes: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW; all other codes, and codes 8-15 when XLEN=32, are illegal.
REQ-013 States: IDLE, CALC, DONE; reset state IDLE.
REQ-014 in_ready SHALL be 1 only in IDLE; accept when in_valid && in_ready; operands and op latched at accept.
REQ-015 IDLE->CALC on accept of a legal op not matching REQ-019/REQ-020 shortcut; IDLE->DONE on accept of a shortcut or illegal op.
REQ-016 CALC performs one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide; N steps, N = XLEN for full ops, 32 for W ops; CALC->DONE after step N.
REQ-017 Latency: out_valid rises exactly N+1 cycles after accept edge for iterative ops, 1 cycle after accept for shortcut/illegal ops.
REQ-018 Signed ops convert operands to magnitude at accept and fix result sign at DONE entry; MULH/MULHSU/MULHU return upper XLEN bits of 2*XLEN product; MUL returns lower XLEN bits.
REQ-019 Divide by zero: quotient = all ones, remainder = dividend (operand width per op), no iteration.
REQ-020 Signed overflow (dividend = most negative, divisor = -1): quotient = dividend, remainder = 0, no iteration.
REQ-021 W ops use src[31:0] only; 32-bit result sign-extended from bit 31 to XLEN, including DIVUW/REMUW.
REQ-022 Illegal op: result = 0, out_valid asserted per REQ-017.
REQ-023 DONE: out_valid=1, result stable until out_valid && out_ready, then -> IDLE; in_ready remains 0 during that handshake cycle (no same-cycle re-accept).
REQ-024 out_ready low holds DONE indefinitely with result unchanged.
REQ-025 flush: from any state -> IDLE next edge, out_valid=0, in_ready=1 next cycle; flush overrides simultaneous accept (request dropped) and simultaneous result handshake (result discarded).
REQ-026 result SHALL be 0 whenever out_valid=0.

Reset
REQ-027 rst_n low: asynchronously state=IDLE, in_ready=1, out_valid=0, result=0, all datapath registers 0.
REQ-028 rst_n asserted mid-CALC or mid-DONE discards the operation; no out_valid after release until a new accept.
REQ-029 First accept possible on first rising clk edge after rst_n deasserts.

Verification
REQ-030 XLEN=64, MUL src1=7, src2=-3 -> out_valid at cycle 65 after accept, result=0xFFFF_FFFF_FFFF_FFEB.
REQ-031 MULHU src1=src2=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE; MULH same operands -> result=0.
REQ-032 DIV src1=-7, src2=2 -> result=-3; REM same -> result=-1; DIVU src1=5, src2=0 -> result=all ones after 1 cycle; REM src1=0x8000_0000_0000_0000, src2=-1 -> result=0 after 1 cycle.
REQ-033 DIVUW src1=0x0000_0000_8000_0000, src2=1 -> out_valid at cycle 33, result=0xFFFF_FFFF_8000_0000; MULW 0x1_0000_0002 * 3 -> result=6.
REQ-034 out_ready held low 10 cycles in DONE -> result stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-035 flush at step 20 of DIV, and rst_n pulse mid-CALC -> no out_valid, in_ready=1 next cycle, next op correct.
